// File: rtl/dp_bram.sv
// rtl/dp_bram.sv - dual-port byte-addressable block RAM with write-collision irq
module dp_bram #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LATENCY     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_enable,
  input  logic                    a_wr_en,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_i_data,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  output logic                    a_ready,
  output logic [DATA_WIDTH-1:0]   a_o_data,
  output logic                    a_bus_err,
  input  logic                    b_enable,
  input  logic                    b_wr_en,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_i_data,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  output logic                    b_ready,
  output logic [DATA_WIDTH-1:0]   b_o_data,
  output logic                    b_bus_err,
  input  logic                    irq_clr,
  output logic                    irq
);

  localparam int BW    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BW);
  localparam int WORDS = DEPTH_BYTES / BW;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Index 0 is port A, index 1 is port B; both ports share the same logic.
  logic [1:0]            en;
  logic [1:0]            wr;
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [DATA_WIDTH-1:0] i_data [2];
  logic [BW-1:0]         be     [2];

  assign en        = {b_enable, a_enable};
  assign wr        = {b_wr_en, a_wr_en};
  assign addr[0]   = a_addr;
  assign addr[1]   = b_addr;
  assign i_data[0] = a_i_data;
  assign i_data[1] = b_i_data;
  assign be[0]     = a_be;
  assign be[1]     = b_be;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  state_t                st      [2];
  logic [1:0]            rdy_q;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic                  irq_q;

  logic [1:0]            acc;
  logic [1:0]            we;
  logic [1:0]            err;
  logic [IDX_W-1:0]      idx   [2];
  logic [OFF_W-1:0]      off   [2];
  logic [BW-1:0]         lmask [2];
  logic [DATA_WIDTH-1:0] wdat  [2];
  logic [DATA_WIDTH-1:0] rdat  [2];
  logic                  coll;

  function automatic logic be_legal(input logic [BW-1:0] m);
    logic ok;
    ok = (m == BW'(1)) || (m == BW'(3)) || (m == BW'(15));
    if (BW == 8) ok = ok || (m == {BW{1'b1}});
    return ok;
  endfunction

  // Illegal mask, misalignment to the access size, or running past the end.
  function automatic logic access_err(input logic [ADDR_WIDTH-1:0] a, input logic [BW-1:0] m);
    int unsigned           sz;
    logic [ADDR_WIDTH-1:0] smask;
    logic [ADDR_WIDTH:0]   last;
    sz    = $countones(m);
    smask = ADDR_WIDTH'(sz - 1);
    last  = {1'b0, a} + (ADDR_WIDTH + 1)'(sz);
    return !be_legal(m) || ((a & smask) != '0) || (last > (ADDR_WIDTH + 1)'(DEPTH_BYTES));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [BW-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < BW; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Per-port address decode, lane steering and old-word read (read-first).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      idx[p]   = addr[p][OFF_W +: IDX_W];
      off[p]   = addr[p][OFF_W-1:0];
      err[p]   = access_err(addr[p], be[p]);
      lmask[p] = be[p] << off[p];
      wdat[p]  = i_data[p] << {off[p], 3'b000};
      rdat[p]  = (mem[idx[p]] >> {off[p], 3'b000}) & byte_mask(be[p]);
      acc[p]   = (st[p] == IDLE) && en[p];
      we[p]    = acc[p] && wr[p] && !err[p] && !rst;
    end
  end

  assign coll = we[0] && we[1] && (idx[0] == idx[1]) && (|(lmask[0] & lmask[1]));

  // Array write: B first so that A's lanes override B's on a collision.
  always_ff @(posedge clk) begin
    for (int q = 1; q >= 0; q--) begin
      if (we[q]) begin
        for (int i = 0; i < BW; i++) begin
          if (lmask[q][i]) mem[idx[q]][8*i +: 8] <= wdat[q][8*i +: 8];
        end
      end
    end
  end

  // Per-port IDLE/WAIT/DONE handshake with registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        st[p]      <= IDLE;
        rdata_q[p] <= '0;
      end
      rdy_q <= 2'b00;
      err_q <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        case (st[p])
          IDLE: begin
            if (en[p]) begin
              err_q[p]   <= err[p];
              rdata_q[p] <= (err[p] || wr[p]) ? '0 : rdat[p];
              if (LATENCY == 1) begin
                st[p]    <= DONE;
                rdy_q[p] <= 1'b1;
              end else begin
                st[p]    <= WAIT;
              end
            end
          end
          WAIT: begin
            st[p]    <= DONE;
            rdy_q[p] <= 1'b1;
          end
          DONE: begin
            if (!en[p]) begin
              st[p]    <= IDLE;
              rdy_q[p] <= 1'b0;
            end
          end
          default: begin
            st[p]    <= IDLE;
            rdy_q[p] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky collision status; a new collision beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          irq_q <= 1'b0;
    else if (coll)    irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end

  assign a_ready   = rdy_q[0];
  assign b_ready   = rdy_q[1];
  assign a_bus_err = err_q[0];
  assign b_bus_err = err_q[1];
  assign a_o_data  = rdata_q[0];
  assign b_o_data  = rdata_q[1];
  assign irq       = irq_q;

endmodule

// File: tb/tb_dp_bram.sv
// tb/tb_dp_bram.sv - self-checking bench for dp_bram at LATENCY 1 and 2 side by side
module tb_dp_bram;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [1:0]  wr;
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [3:0]  be   [2];
  logic        irq_clr;

  // Index q = 2*k + p: k=0 is the LATENCY=1 instance, k=1 the LATENCY=2 one.
  wire [3:0]   rdy;
  wire [3:0]   berr;
  wire [1:0]   irqo;
  wire [31:0]  od [4];

  logic [7:0]  mm [DEPTH];
  bit          m_irq;
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] got     [2];
  logic        got_err [2];

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_rd;
    bit          chk_rd;
  } vec_t;

  vec_t        tbl [22];
  logic [3:0]  be_pick [7] = '{4'h1, 4'h3, 4'hF, 4'hF, 4'h0, 4'h5, 4'h2};

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dp_bram #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(k + 1)) u_dut (
      .clk(clk), .rst(rst),
      .a_enable(en[0]), .a_wr_en(wr[0]), .a_addr(addr[0]), .a_i_data(din[0]), .a_be(be[0]),
      .a_ready(rdy[2*k]), .a_o_data(od[2*k]), .a_bus_err(berr[2*k]),
      .b_enable(en[1]), .b_wr_en(wr[1]), .b_addr(addr[1]), .b_i_data(din[1]), .b_be(be[1]),
      .b_ready(rdy[2*k+1]), .b_o_data(od[2*k+1]), .b_bus_err(berr[2*k+1]),
      .irq_clr(irq_clr), .irq(irqo[k])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int m_size(input logic [3:0] b);
    case (b)
      4'h1:    return 1;
      4'h3:    return 2;
      4'hF:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic [3:0] b);
    int s;
    s = m_size(b);
    if (s == 0) return 1'b1;
    if ((a % 32'(s)) != 0) return 1'b1;
    if (longint'(a) + s > DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input int s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < s; i++) r = r | (32'(mm[10'(int'(a) + i)]) << (8 * i));
    return r;
  endfunction

  // One transaction on either or both ports, accepted on the same edge.
  task automatic do_pair(input bit ea, input bit wa, input logic [31:0] aa, input logic [3:0] ba,
                         input logic [31:0] da,
                         input bit eb, input bit wb, input logic [31:0] ab, input logic [3:0] bb,
                         input logic [31:0] db, input bit clr);
    bit          e [2];
    bit          w [2];
    logic [31:0] a [2];
    logic [3:0]  b [2];
    logic [31:0] d [2];
    bit          xerr [2];
    logic [31:0] xrd [2];
    int          s [2];
    bit          coll;
    int          lat [4];
    logic [31:0] gd [4];
    logic        ge [4];
    bit          done;
    e[0] = ea; w[0] = wa; a[0] = aa; b[0] = ba; d[0] = da;
    e[1] = eb; w[1] = wb; a[1] = ab; b[1] = bb; d[1] = db;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      s[p]    = m_size(b[p]);
      xerr[p] = m_err(a[p], b[p]);
      xrd[p]  = xerr[p] ? 32'h0 : m_read(a[p], s[p]);
    end
    coll = e[0] && e[1] && w[0] && w[1] && !xerr[0] && !xerr[1] &&
           (a[0] < a[1] + 32'(s[1])) && (a[1] < a[0] + 32'(s[0]));
    for (int p = 1; p >= 0; p--) begin
      if (e[p] && w[p] && !xerr[p]) begin
        for (int i = 0; i < s[p]; i++) mm[10'(int'(a[p]) + i)] = d[p][8*i +: 8];
      end
    end
    m_irq = coll ? 1'b1 : (clr ? 1'b0 : m_irq);
    for (int p = 0; p < 2; p++) begin
      en[p] = e[p]; wr[p] = w[p]; addr[p] = a[p]; be[p] = b[p]; din[p] = d[p];
    end
    irq_clr = clr;
    for (int q = 0; q < 4; q++) begin
      lat[q] = 0; gd[q] = '0; ge[q] = 1'b0;
    end
    done = 1'b0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      irq_clr = 1'b0;
      for (int q = 0; q < 4; q++) begin
        if (rdy[q] && lat[q] == 0) begin
          lat[q] = c; gd[q] = od[q]; ge[q] = berr[q];
        end
      end
      done = 1'b1;
      for (int q = 0; q < 4; q++) if (e[q % 2] && lat[q] == 0) done = 1'b0;
    end
    for (int q = 0; q < 4; q++) begin
      if (e[q % 2]) begin
        chk($sformatf("latency L%0d port%0d", q / 2 + 1, q % 2), lat[q], q / 2 + 1);
        chk($sformatf("bus_err L%0d port%0d", q / 2 + 1, q % 2), 32'(ge[q]), 32'(xerr[q % 2]));
        if (xerr[q % 2] || !w[q % 2])
          chk($sformatf("o_data L%0d port%0d @%h", q / 2 + 1, q % 2, a[q % 2]), gd[q], xrd[q % 2]);
      end
    end
    for (int k = 0; k < 2; k++) chk($sformatf("irq L%0d", k + 1), 32'(irqo[k]), 32'(m_irq));
    got[0] = gd[0]; got[1] = gd[1]; got_err[0] = ge[0]; got_err[1] = ge[1];
    en = 2'b00;
    @(negedge clk);
    chk("ready after enable drop", 32'(rdy), 32'h0);
  endtask

  task automatic do_op(input bit p, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    if (p == 1'b0) do_pair(1'b1, w, a, b, d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    else           do_pair(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, w, a, b, d, 1'b0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    m_irq = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("irq cleared L%0d", k + 1), 32'(irqo[k]), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          re [2];
    bit          rw [2];
    logic [31:0] ra [2];
    logic [3:0]  rb [2];

    tbl[0]  = '{1'b0, 1'b1, 32'h010, 4'hF, 32'h11223344, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h010, 4'h3, 32'h0,        1'b0, 32'h00003344, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 32'h012, 4'h3, 32'h0,        1'b0, 32'h00001122, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 32'h013, 4'h1, 32'h0,        1'b0, 32'h00000011, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'h010, 4'h1, 32'h77,       1'b0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h011, 4'h1, 32'h88,       1'b0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h012, 4'h1, 32'h99,       1'b0, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h013, 4'h1, 32'hAA,       1'b0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h010, 4'hF, 32'h0,        1'b0, 32'hAA998877, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'h001, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 1'b1, 32'h002, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h003, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 1'b1, 32'h001, 4'h3, 32'h00005678, 1'b1, 32'h0,        1'b1};
    tbl[14] = '{1'b1, 1'b0, 32'h000, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 32'h400, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b1};
    tbl[16] = '{1'b0, 1'b1, 32'h3FF, 4'h3, 32'h00001234, 1'b1, 32'h0,        1'b1};
    tbl[17] = '{1'b0, 1'b1, 32'h000, 4'h5, 32'h12345678, 1'b1, 32'h0,        1'b1};
    tbl[18] = '{1'b1, 1'b1, 32'h3FF, 4'h1, 32'h5C,       1'b0, 32'h0,        1'b0};
    tbl[19] = '{1'b1, 1'b0, 32'h3FF, 4'h1, 32'h0,        1'b0, 32'h0000005C, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 32'h002, 4'h3, 32'h0,        1'b0, 32'h0000DEAD, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 32'h000, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1};

    rst = 1'b1; en = 2'b00; wr = 2'b00; irq_clr = 1'b0; m_irq = 1'b0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; din[p] = '0; be[p] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(rdy), 32'h0);
    chk("reset bus_err", 32'(berr), 32'h0);
    chk("reset irq", 32'(irqo), 32'h0);
    for (int q = 0; q < 4; q++) chk($sformatf("reset o_data %0d", q), od[q], 32'h0);
    rst = 1'b0;

    // Fill the whole array so every later read has a known reference.
    for (int i = 0; i < 128; i++)
      do_pair(1'b1, 1'b1, 32'(4 * i), 4'hF, $urandom,
              1'b1, 1'b1, 32'(4 * (i + 128)), 4'hF, $urandom, 1'b0);

    for (int i = 0; i < 22; i++) begin
      do_op(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].data);
      chk($sformatf("tbl%0d bus_err", i), 32'(got_err[tbl[i].port]), 32'(tbl[i].exp_err));
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d o_data", i), got[tbl[i].port], tbl[i].exp_rd);
    end

    // Collision: A's lanes win, B's remaining lanes land, irq sets.
    do_pair(1'b1, 1'b1, 32'h20, 4'h3, 32'h0000BEEF, 1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0);
    chk("collision irq", 32'(irqo), 32'h3);
    do_op(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    chk("collision merge", got[1], 32'hCAFEBEEF);
    pulse_clr();
    do_pair(1'b1, 1'b1, 32'h21, 4'h1, 32'h11, 1'b1, 1'b1, 32'h20, 4'h3, 32'h2222, 1'b1);
    chk("set beats clear", 32'(irqo), 32'h3);

    // Read-first: A sees the word as it was before B's same-edge write.
    do_pair(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h01020304, 1'b0);
    chk("read-first", got[0], 32'hAA998877);

    // Enable dropped one cycle after accept: LATENCY=2 still pulses ready once.
    @(negedge clk);
    en = 2'b01; wr = 2'b00; addr[0] = 32'h10; be[0] = 4'hF;
    @(negedge clk);
    chk("L1 ready after E0", 32'(rdy[0]), 32'h1);
    chk("L2 ready low after E0", 32'(rdy[2]), 32'h0);
    en = 2'b00;
    @(negedge clk);
    chk("L1 ready after drop", 32'(rdy[0]), 32'h0);
    chk("L2 ready pulse", 32'(rdy[2]), 32'h1);
    chk("L2 pulse data", od[2], 32'h01020304);
    @(negedge clk);
    chk("L2 ready pulse end", 32'(rdy[2]), 32'h0);

    // Reset with L2 port A in DONE (write committed) and port B in WAIT (read pending).
    @(negedge clk);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h40; be[0] = 4'hF; din[0] = 32'h5A5A1234;
    for (int i = 0; i < 4; i++) mm[10'(32'h40 + i)] = din[0][8*i +: 8];
    @(negedge clk);
    en[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40; be[1] = 4'hF;
    @(negedge clk);
    chk("pre-reset L2 A done", 32'(rdy[2]), 32'h1);
    chk("pre-reset L2 B wait", 32'(rdy[3]), 32'h0);
    chk("pre-reset L1 B data", od[1], 32'h5A5A1234);
    chk("pre-reset irq", 32'(irqo), 32'h3);
    rst = 1'b1; en = 2'b00;
    #1;
    chk("mid reset ready", 32'(rdy), 32'h0);
    chk("mid reset bus_err", 32'(berr), 32'h0);
    chk("mid reset irq", 32'(irqo), 32'h0);
    for (int q = 0; q < 4; q++) chk($sformatf("mid reset o_data %0d", q), od[q], 32'h0);
    @(negedge clk);
    rst = 1'b0; m_irq = 1'b0;
    do_op(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
    chk("write kept over reset", got[0], 32'h5A5A1234);

    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        re[p] = ($urandom_range(0, 3) != 0);
        rw[p] = 1'($urandom_range(0, 1));
        ra[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1100)) : 32'($urandom_range(0, 47));
        rb[p] = be_pick[$urandom_range(0, 6)];
      end
      if (!re[0] && !re[1]) re[0] = 1'b1;
      do_pair(re[0], rw[0], ra[0], rb[0], $urandom, re[1], rw[1], ra[1], rb[1], $urandom,
              ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
